// File: rtl/store_buffer.sv
// M-stage store buffer: lane-aligned, byte-enabled stores in a FIFO
// with optional write combining into the youngest entry.
module store_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int MERGE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [2:0]               in_op,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [31:0]              in_wd,
  output logic                     in_ready,
  output logic                     exc_ades,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W/8-1:0]      mem_byteen,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int NB = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] e_addr [DEPTH];
  logic [NB-1:0]     e_be   [DEPTH];
  logic [DATA_W-1:0] e_wd   [DEPTH];

  logic [PW-1:0]     head, tail, prev, idx;
  logic [CW-1:0]     cnt;
  logic              is_sw, is_sh, is_sb, st, mis, lane;
  logic              merge_ok, acc, push, mrg, pop;
  logic [3:0]        be4;
  logic [31:0]       wd32;
  logic [NB-1:0]     nbe;
  logic [DATA_W-1:0] nwd, mwd;
  logic [ADDR_W-1:0] nadr, lda, amask;

  always_comb begin
    is_sw = in_op == 3'd1;
    is_sh = in_op == 3'd2;
    is_sb = in_op == 3'd3;
    st    = is_sw | is_sh | is_sb;
    mis   = (is_sw & (in_addr[1:0] != 2'b00))
          | (is_sh & in_addr[0]);
    exc_ades = in_valid & mis;
    lane  = (NB == 8) ? in_addr[2] : 1'b0;
    be4   = '0;
    wd32  = '0;
    unique case (1'b1)
      is_sw: begin
        be4  = 4'b1111;
        wd32 = in_wd;
      end
      is_sh: begin
        be4  = 4'b0011 << in_addr[1:0];
        wd32 = {2{in_wd[15:0]}};
      end
      is_sb: begin
        be4  = 4'b0001 << in_addr[1:0];
        wd32 = {4{in_wd[7:0]}};
      end
      default: ;
    endcase
    nbe   = NB'(be4) << (lane ? 4 : 0);
    nwd   = DATA_W'(wd32) << (lane ? 32 : 0);
    amask = ~ADDR_W'(NB - 1);
    nadr  = in_addr & amask;
    prev  = tail - PW'(1);
    // count>=2 keeps the merge target away from the head entry
    merge_ok = (MERGE != 0)
             & (cnt >= CW'(2))
             & (e_addr[prev] == nadr);
    in_ready = (cnt < CW'(DEPTH)) | merge_ok;
    acc   = in_valid & st & ~mis & in_ready;
    push  = acc & ~merge_ok;
    mrg   = acc & merge_ok;
    mem_valid = cnt != '0;
    pop   = mem_valid & mem_ready;
    mwd   = e_wd[prev];
    for (int i = 0; i < NB; i++) begin
      if (nbe[i]) mwd[8*i +: 8] = nwd[8*i +: 8];
    end
  end

  always_comb begin
    ld_hit = 1'b0;
    idx    = '0;
    lda    = ld_addr & amask;
    for (int i = 0; i < DEPTH; i++) begin
      idx = PW'(i) - head;
      if ((CW'(idx) < cnt) && (e_addr[i] == lda))
        ld_hit = 1'b1;
    end
  end

  assign mem_addr   = mem_valid ? e_addr[head] : '0;
  assign mem_byteen = mem_valid ? e_be[head]   : '0;
  assign mem_wdata  = mem_valid ? e_wd[head]   : '0;
  assign count      = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_be[i]   <= '0;
        e_wd[i]   <= '0;
      end
    end else begin
      if (push) begin
        e_addr[tail] <= nadr;
        e_be[tail]   <= nbe;
        e_wd[tail]   <= nwd;
        tail         <= tail + PW'(1);
      end
      if (mrg) begin
        e_be[prev] <= e_be[prev] | nbe;
        e_wd[prev] <= mwd;
      end
      if (pop) head <= head + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Parametrised store buffer for the M stage: it turns sw/sh/sb requests into byte-enabled, lane-aligned writes, queues them in a DEPTH-entry FIFO and drains them to the data memory or bridge through a valid/ready handshake. Memory data width is parametrised to 32 or 64 bits. Optionally, consecutive stores to the same memory word are merged into the youngest entry. It also flags misaligned stores (AdES) and reports load-address hits against pending entries so the hazard unit can stall loads.

## Interface
- DATA_W, 32: memory data width; legal values 32 or 64.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_W, 32: byte address width.
- MERGE, 1: 1 enables write combining into the youngest entry; 0 disables it.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  store request valid.
- in_op  in  3  store type: 3'd0 none, 3'd1 sw, 3'd2 sh, 3'd3 sb; 3'd4–7 are treated as none.
- in_addr  in  ADDR_W  byte address.
- in_wd  in  32  register data (low bits used for sh/sb).
- in_ready  out  1  buffer can accept this cycle.
- exc_ades  out  1  misaligned store.
- mem_valid  out  1  head entry valid.
- mem_ready  in  1  memory accepts head.
- mem_addr  out  ADDR_W  head address, aligned to DATA_W/8.
- mem_byteen  out  DATA_W/8  head byte enables.
- mem_wdata  out  DATA_W  head write data, lane-positioned.
- ld_addr  in  ADDR_W  address of a load in M.
- ld_hit  out  1  some valid entry has the same aligned address as ld_addr.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- **Alignment:** misaligned means sw with addr[1:0]≠0, or sh with addr[0]≠0.
  - exc_ades = in_valid & (op is sw/sh) & misaligned. It is combinational.
  - A misaligned store is never enqueued.
- **Accept:** acc = in_valid & op∈{sw,sh,sb} & ~exc_ades & in_ready. With op none, nothing happens.
- **Lane select:** word lane w = addr[2] when DATA_W=64, else 0. Byte offset b = addr[1:0].
  - sw: byteen 4'b1111 in lane w; data = wd.
  - sh: byteen 4'b0011<<b; data = wd[15:0] replicated in both halves.
  - sb: byteen 4'b0001<<b; data = wd[7:0] replicated in all four bytes.
  - Lane w gets the 4 enables and 32 data bits; the other lane has byteen 0 and data 0.
- **Entry contents:** {aligned addr = addr with low $clog2(DATA_W/8) bits cleared, byteen, wdata}.
- **Merge:** merge_ok = MERGE & count≥2 & tail-1 entry address == new aligned address.
  - On merge, each byte with a new enable set is overwritten, and byteen |= new byteen. count is unchanged.
  - The head entry is never merged into, because it may be mid-handshake.
- **Push:** if acc & ~merge_ok, write the entry at tail and advance tail (mod DEPTH).
- **Readiness:** in_ready = (count<DEPTH) | merge_ok. It does not depend on mem_ready.
- **Pop:** when mem_valid & mem_ready, advance head. Push and pop in the same cycle leave count unchanged. Pop and merge in the same cycle are legal, because the merge target is never the head.
- **Memory outputs:** mem_valid = count≠0. mem_* show the head entry; with count=0, mem_addr, mem_byteen and mem_wdata are 0.
- **Load hit:** ld_hit = OR over valid entries of (entry addr == aligned ld_addr). It covers stored entries only; this cycle's incoming store is excluded.

## Timing
- **Reset (async, active-low):** count=0, head=tail=0, all entries cleared. Outputs are then mem_valid=0, mem_addr/byteen/wdata=0, ld_hit=0, in_ready=1. exc_ades remains combinational on its inputs during reset.
- **Reset mid-operation:** pending stores are discarded. Nothing is issued after reset deasserts until a new accept.
- **Latency:** a store accepted at edge t into an empty buffer gives mem_valid=1 with its data from t+1.
- **Drain rate:** with mem_ready held high, one entry drains per cycle.
- **Handshake:** mem_addr, mem_byteen and mem_wdata stay stable while mem_valid=1 and mem_ready=0.
- **Full:** count=DEPTH. in_ready=0 unless merge_ok; a simultaneous pop does not raise in_ready that cycle.
- **Pointers:** wrap modulo DEPTH. count distinguishes full from empty.

## Test plan
- **Basic sw:** DATA_W=32, empty buffer, sw addr 0x100 wd 0xDEADBEEF with mem_ready=0 -> next cycle mem_valid=1, mem_addr 0x100, byteen 4'b1111, wdata 0xDEADBEEF. Raise mem_ready -> count goes 1→0.
- **Lane placement:** DATA_W=64, sb addr 0x107 wd 0x55 -> mem_addr 0x100, byteen 8'h80, wdata[63:56]=0x55. Then sh addr 0x102 wd 0x1234 -> byteen 8'h0C, wdata[31:16]=0x1234.
- **Merge:** MERGE=1, mem_ready=0, sw 0x200 then sb 0x300 wd 0x11 then sb 0x301 wd 0x22 -> count=2; tail entry byteen 4'b0011, data low half 0x2211. With MERGE=0 the same sequence gives count=3.
- **Misaligned:** sw 0x102, then sh 0x101 -> exc_ades=1 each cycle, count unchanged. sb 0x103 -> exc_ades=0, store accepted.
- **Full/wrap:** DEPTH=4, mem_ready=0, five sw to distinct words -> in_ready=0 after four. Pulse mem_ready for one cycle -> the fifth is accepted the next cycle. Drain all -> addresses come out in FIFO order across the pointer wrap.
- **Load hit and reset:** pending sw 0x40 with ld_addr 0x42 -> ld_hit=1; ld_addr 0x44 -> ld_hit=0. Assert reset with 3 entries pending -> mem_valid=0 and count=0 immediately, without waiting for a clock edge.
